// File: rtl/video_pkg.sv
// Shared video constants, capture FSM state type and pixel-format helpers used by the capture
// path and the timing-generator side.
package video_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    // Wide enough for any line/frame size the capture path is expected to see.
    localparam int unsigned CNT_W        = 12;

    typedef enum logic [1:0] {
        StSyncWait,
        StFrameWait,
        StCapture,
        StDrop
    } vcap_state_e;

    // Truncating RGB888 -> RGB565 conversion.
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/video_sync_detect.sv
// Registers the raw video inputs once and derives polarity-normalised edge pulses for
// hsync, vsync and data enable from the registered copies.
module video_sync_detect #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_hsync,
    input  logic        vid_vsync,
    input  logic        vid_de,
    input  logic [23:0] vid_rgb,
    output logic        de,
    output logic [23:0] rgb,
    output logic        hs_rise,
    output logic        vs_rise,
    output logic        vs_fall,
    output logic        de_fall
);

    logic        hs_d, hs_q, hs_prev_d, hs_prev_q;
    logic        vs_d, vs_q, vs_prev_d, vs_prev_q;
    logic        de_d, de_q, de_prev_d, de_prev_q;
    logic [23:0] rgb_d, rgb_q;

    // Syncs are stored as "asserted" flags so everything downstream is polarity-agnostic.
    always_comb begin
        hs_d      = (vid_hsync == SYNC_POL);
        vs_d      = (vid_vsync == SYNC_POL);
        de_d      = vid_de;
        rgb_d     = vid_rgb;
        hs_prev_d = hs_q;
        vs_prev_d = vs_q;
        de_prev_d = de_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            rgb_q     <= '0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            rgb_q     <= rgb_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            de_prev_q <= de_prev_d;
        end
    end

    assign de      = de_q;
    assign rgb     = rgb_q;
    assign hs_rise = hs_q & ~hs_prev_q;
    assign vs_rise = vs_q & ~vs_prev_q;
    assign vs_fall = ~vs_q & vs_prev_q;
    assign de_fall = ~de_q & de_prev_q;

endmodule

// File: rtl/video_capture_downscaler.sv
// Captures a video stream, keeps every other pixel of every other line and writes RGB565 to a
// pixel FIFO. Define VCAP_TEST_PATTERN_EN to add the tp_en coordinate test-pattern input.
module video_capture_downscaler
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_hsync,
    input  logic        vid_vsync,
    input  logic        vid_de,
    input  logic [23:0] vid_rgb,
`ifdef VCAP_TEST_PATTERN_EN
    input  logic        tp_en,
`endif
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        sof,
    output logic        frame_done,
    output logic        overflow,
    output logic        line_err
);

    localparam logic [CNT_W-1:0] HCnt  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VLast = CNT_W'(V_ACTIVE - 1);

    logic        de, hs_rise, vs_rise, vs_fall, de_fall;
    logic [23:0] rgb;

    video_sync_detect #(
        .SYNC_POL (SYNC_POL)
    ) u_sync_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .vid_hsync (vid_hsync),
        .vid_vsync (vid_vsync),
        .vid_de    (vid_de),
        .vid_rgb   (vid_rgb),
        .de        (de),
        .rgb       (rgb),
        .hs_rise   (hs_rise),
        .vs_rise   (vs_rise),
        .vs_fall   (vs_fall),
        .de_fall   (de_fall)
    );

    vcap_state_e      state_d, state_q;
    logic             armed_d, armed_q;
    logic [CNT_W-1:0] x_cnt_d, x_cnt_q;
    logic [CNT_W-1:0] y_cnt_d, y_cnt_q;
    logic             keep_d, keep_q;
    logic             first_d, first_q;
    logic [15:0]      pix_d, pix_q;
    logic             wr_en_d, wr_en_q;
    logic [15:0]      wr_data_d, wr_data_q;
    logic             sof_d, sof_q;
    logic             frame_done_d, frame_done_q;
    logic             overflow_d, overflow_q;
    logic             line_err_d, line_err_q;
    logic             take_px, counting, drop_now;

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        keep_d       = 1'b0;
        first_d      = 1'b0;
        pix_d        = pix_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        sof_d        = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        line_err_d   = line_err_q;
        take_px      = 1'b0;
        counting     = 1'b0;
        drop_now     = keep_q & fifo_full;

        // Write stage: a pixel decided one cycle ago is committed now, or lost to a full FIFO.
        if (keep_q) begin
            if (fifo_full) begin
                overflow_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = pix_q;
                sof_d     = first_q;
            end
        end

        unique case (state_q)
            StSyncWait: begin
                if (vs_fall) begin
                    state_d = StFrameWait;
                    armed_d = 1'b1;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                end
            end
            StFrameWait: begin
                if (vs_fall) begin
                    armed_d = 1'b1;
                end else if (armed_q && de) begin
                    state_d = StCapture;
                    armed_d = 1'b0;
                    take_px = 1'b1;
                end
            end
            StCapture: begin
                counting = 1'b1;
                take_px  = de & ~drop_now;
                if (drop_now) state_d = StDrop;
            end
            StDrop: begin
                counting = 1'b1;
            end
            default: ;
        endcase

        if ((counting || take_px) && de) x_cnt_d = x_cnt_q + 1'b1;

        if (take_px) begin
            keep_d  = ~x_cnt_q[0] & ~y_cnt_q[0];
            first_d = (x_cnt_q == '0) && (y_cnt_q == '0);
`ifdef VCAP_TEST_PATTERN_EN
            pix_d   = tp_en ? {x_cnt_q[9:5], y_cnt_q[8:3], x_cnt_q[5:1]} : rgb888_to_565(rgb);
`else
            pix_d   = rgb888_to_565(rgb);
`endif
        end

        if (counting && de_fall) begin
            if (x_cnt_q != HCnt) line_err_d = 1'b1;
            x_cnt_d = '0;
            y_cnt_d = y_cnt_q + 1'b1;
            if (state_q == StCapture && y_cnt_q == VLast) begin
                state_d      = StFrameWait;
                y_cnt_d      = '0;
                frame_done_d = 1'b1;
            end
        end

        // hsync only re-aligns the pixel counter outside active video.
        if (hs_rise && !de) x_cnt_d = '0;

        // A new vsync assertion abandons whatever frame was in progress.
        if (vs_rise) begin
            state_d      = StFrameWait;
            armed_d      = 1'b0;
            x_cnt_d      = '0;
            y_cnt_d      = '0;
            keep_d       = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StSyncWait;
            armed_q      <= 1'b0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            keep_q       <= 1'b0;
            first_q      <= 1'b0;
            pix_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            sof_q        <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            keep_q       <= keep_d;
            first_q      <= first_d;
            pix_q        <= pix_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            sof_q        <= sof_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            line_err_q   <= line_err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign sof        = sof_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign line_err   = line_err_q;

endmodule

// File: tb/tb_video_capture_downscaler.sv
// Scoreboard bench for video_capture_downscaler on a reduced 16x8 frame with random pixels.
module tb_video_capture_downscaler;

    localparam int unsigned H  = 16;
    localparam int unsigned V  = 8;
    localparam bit          SP = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_hsync, vid_vsync, vid_de, fifo_full;
    logic [23:0] vid_rgb;
    logic        wr_en, sof, frame_done, overflow, line_err;
    logic [15:0] wr_data;
`ifdef VCAP_TEST_PATTERN_EN
    logic        tp_en = 1'b0;
`endif

    always #5 clk = ~clk;

    video_capture_downscaler #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .SYNC_POL (SP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vid_hsync  (vid_hsync),
        .vid_vsync  (vid_vsync),
        .vid_de     (vid_de),
        .vid_rgb    (vid_rgb),
`ifdef VCAP_TEST_PATTERN_EN
        .tp_en      (tp_en),
`endif
        .fifo_full  (fifo_full),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .sof        (sof),
        .frame_done (frame_done),
        .overflow   (overflow),
        .line_err   (line_err)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, n_wr = 0, n_done = 0;
    int   cyc = 0, full_lo = -10, full_hi = -10;
    int   exp_wr = 0, exp_done = 0;
    logic exp_ovf = 1'b0, exp_lerr = 1'b0;
    bit   capt_ok, dropped;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    function automatic bit full_at(input int c);
        return (c >= full_lo) && (c < full_hi);
    endfunction

    // One clock of stimulus; cyc numbers the rising edge that samples these values.
    task automatic tick(input bit hs, input bit vs, input bit de, input logic [23:0] rgb);
        @(negedge clk);
        cyc++;
        vid_hsync = hs ? SP : ~SP;
        vid_vsync = vs ? SP : ~SP;
        vid_de    = de;
        vid_rgb   = de ? rgb : 24'h0;
        fifo_full = full_at(cyc);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", {11'd0, wr_en, wr_data, sof, frame_done, overflow, line_err}, 0);
        #1 rst_n = 1'b1;
        capt_ok  = 0;
        exp_ovf  = 1'b0;
        exp_lerr = 1'b0;
    endtask

    // Sends one frame (vsync, back porch, lines, front porch) and predicts the writes.
    task automatic send_frame(input int mode, input int n_lines, input int short_row,
                              input int reset_row, input int full_row, input bit de_in_vs);
        logic [23:0] p;
        exp_t        e;
        int          len;
        capt_ok = 1;
        dropped = 0;
        for (int i = 0; i < 3; i++) tick(0, 1, de_in_vs, 24'($urandom));
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 24'h0);
        for (int y = 0; y < n_lines; y++) begin
            len = (y == short_row) ? H - 2 : H;
            if (y == full_row) begin
                full_lo = cyc + 7;
                full_hi = cyc + 10;
            end
            for (int x = 0; x < len; x++) begin
                case (mode)
                    0:       p = 24'hFF8040;
                    1:       p = 24'(x + 1000 * y);
                    default: p = 24'($urandom);
                endcase
                tick(0, 0, 1, p);
                if (y == reset_row && x == len / 2) pulse_reset();
                if (capt_ok && !dropped && x % 2 == 0 && y % 2 == 0) begin
                    if (full_at(cyc + 2)) begin
                        dropped = 1;
                        exp_ovf = 1'b1;
                    end else begin
                        e.data = to565(p);
                        e.sof  = (x == 0 && y == 0);
                        sb.push_back(e);
                        exp_wr++;
                    end
                end
            end
            if (capt_ok && len != H) exp_lerr = 1'b1;
            tick(0, 0, 0, 24'h0);
            tick(0, 0, 0, 24'h0);
            tick(1, 0, 0, 24'h0);
            tick(1, 0, 0, 24'h0);
            tick(0, 0, 0, 24'h0);
            tick(0, 0, 0, 24'h0);
        end
        if (capt_ok && !dropped && n_lines == V) exp_done++;
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 24'h0);
        full_lo = -10;
        full_hi = -10;
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_writes"}, n_wr, exp_wr);
        check({tag, "_frame_done"}, n_done, exp_done);
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        check({tag, "_line_err"}, {31'd0, line_err}, {31'd0, exp_lerr});
        check({tag, "_pending"}, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (wr_en) begin
            n_wr++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got wr_data=%h, required no write", wr_data);
            end else begin
                e = sb.pop_front();
                check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                check("sof", {31'd0, sof}, {31'd0, e.sof});
            end
        end else if (sof) begin
            check("sof_without_wr_en", {31'd0, sof}, 0);
        end
        if (frame_done) begin
            n_done++;
            check("frame_done_after_last_write", sb.size(), 0);
        end
    end

    initial begin
        rst_n     = 1'b1;
        vid_hsync = ~SP;
        vid_vsync = ~SP;
        vid_de    = 1'b0;
        vid_rgb   = 24'h0;
        fifo_full = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset_state", {11'd0, wr_en, wr_data, sof, frame_done, overflow, line_err}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 24'h0);

        send_frame(0, V, -1, -1, -1, 0);
        end_checks("const_frame");
        send_frame(1, V, -1, -1, -1, 0);
        end_checks("xy_frame");
        send_frame(2, V, -1, -1, 4, 0);
        end_checks("overflow_frame");
        send_frame(2, V, -1, -1, -1, 0);
        end_checks("after_overflow");
        send_frame(2, V, 2, -1, -1, 0);
        end_checks("short_line");
        send_frame(2, 5, -1, -1, -1, 0);
        end_checks("abort_frame");
        send_frame(2, V, -1, -1, -1, 1);
        end_checks("after_abort");
        send_frame(2, V, -1, 3, -1, 0);
        end_checks("reset_frame");
        send_frame(2, V, -1, -1, -1, 0);
        end_checks("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
